// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree, with N = 2**SEL_W channels of DATA_W bits each.
// Each of the SEL_W layers of 2:1 selection is followed by a register, so the
// tree accepts one word per clock. The latency is SEL_W cycles: layer 1 is
// registered on the edge that accepts the item. A valid flag and the selected
// channel tag travel with the data. A global stall freezes the pipeline and the
// scan counter.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  accept one selection this cycle (ignored while stall=1)
//   in_data   packed channels, channel i at [i*DATA_W +: DATA_W]
//   sel       channel index when mode=0
//   mode      0 = external sel, 1 = auto-scan using scan_idx
//   stall     hold every stage and the scan counter
//   out_valid out_data/out_ch carry a fresh result this cycle
//   out_data  selected channel data; holds the last valid result otherwise
//   out_ch    channel index that produced out_data
//   scan_idx  current auto-scan counter
module mux_tree_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [(2**SEL_W)*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         mode,
  input  logic                         stall,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [SEL_W-1:0]             out_ch,
  output logic [SEL_W-1:0]             scan_idx
);

  localparam int unsigned N = 2**SEL_W;

  logic [SEL_W-1:0] eff_sel;
  logic             accept;

  assign eff_sel = mode ? scan_idx : sel;
  assign accept  = in_valid && !stall;

  // The counter width equals the select width, so it wraps from N-1 to 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx <= '0;
    end else if (accept && mode) begin
      scan_idx <= scan_idx + 1'b1;
    end
  end

  // Stage 0 is the unregistered input. Stage k holds N>>k words. The full tag is
  // carried along, and layer k steers with bit k-1 of the tag held by stage k-1.
  for (genvar k = 0; k <= SEL_W; k++) begin : g_stage
    localparam int unsigned Words = N >> k;

    logic [Words*DATA_W-1:0] data;
    logic [SEL_W-1:0]        tag;
    logic                    valid;

    if (k == 0) begin : g_in
      assign data  = in_data;
      assign tag   = eff_sel;
      assign valid = in_valid;
    end else begin : g_reg
      logic [Words*DATA_W-1:0] mux;

      always_comb begin
        mux = '0;
        for (int j = 0; j < int'(Words); j++) begin
          mux[j*DATA_W +: DATA_W] = g_stage[k-1].tag[k-1] ?
              g_stage[k-1].data[(2*j+1)*DATA_W +: DATA_W] :
              g_stage[k-1].data[(2*j)*DATA_W +: DATA_W];
        end
      end

      // Valid follows the previous stage on every unstalled edge. The payload loads
      // only behind a valid item, so a bubble leaves the last result in place.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid <= 1'b0;
          data  <= '0;
          tag   <= '0;
        end else if (!stall) begin
          valid <= g_stage[k-1].valid;
          if (g_stage[k-1].valid) begin
            data <= mux;
            tag  <= g_stage[k-1].tag;
          end
        end
      end
    end
  end

  assign out_valid = g_stage[SEL_W].valid;
  assign out_data  = g_stage[SEL_W].data;
  assign out_ch    = g_stage[SEL_W].tag;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe (DATA_W=8, SEL_W=3).
// A reference model treats the tree as a SEL_W-slot delay line of already-selected
// words, channel[es]. A compare process checks every output on each falling edge.
// Directed literal checks pin the latency, the hold behaviour and the scan counter.
module tb_mux_tree_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned N  = 1 << SW;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [N*DW-1:0] in_data;
  logic [SW-1:0]   sel;
  logic            mode;
  logic            stall;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic [SW-1:0]   scan_idx;

  always #5 clk = ~clk;

  mux_tree_pipe #(
    .DATA_W (DW),
    .SEL_W  (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .scan_idx  (scan_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: item slots in flight, the last delivered result, and the scan count.
  logic          m_v [SW];
  logic [DW-1:0] m_d [SW];
  logic [SW-1:0] m_c [SW];
  logic [DW-1:0] m_last_d;
  logic [SW-1:0] m_last_c;
  int            m_scan;

  task automatic model_step();
    logic [SW-1:0] es;
    if (rst) begin
      for (int i = 0; i < int'(SW); i++) begin
        m_v[i] = 1'b0;
        m_d[i] = '0;
        m_c[i] = '0;
      end
      m_last_d = '0;
      m_last_c = '0;
      m_scan   = 0;
    end else if (!stall) begin
      for (int i = int'(SW) - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_d[i] = m_d[i-1];
        m_c[i] = m_c[i-1];
      end
      es     = mode ? SW'(m_scan) : sel;
      m_v[0] = in_valid;
      m_d[0] = in_data[es*DW +: DW];
      m_c[0] = es;
      if (in_valid && mode) m_scan = (m_scan + 1) % int'(N);
      if (m_v[SW-1]) begin
        m_last_d = m_d[SW-1];
        m_last_c = m_c[SW-1];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(SW); i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
      m_c[i] = '0;
    end
    m_last_d = '0;
    m_last_c = '0;
    m_scan   = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("out_valid", out_valid, m_v[SW-1]);
        check("out_data", out_data, m_last_d);
        check("out_ch", out_ch, m_last_c);
        check("scan_idx", scan_idx, m_scan);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < int'(N); i++) in_data[i*DW +: DW] = 8'hA0 + 8'(i);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    sel      = '0;
    mode     = 1'b0;
    stall    = 1'b0;
    set_pattern();

    // Reset for two cycles, then idle.
    tick();
    checking = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_out_ch", out_ch, 0);
    check("idle_scan", scan_idx, 0);

    // A single pulse on sel=5 emerges SEL_W edges later, then the data holds.
    sel      = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_edge1_valid", out_valid, 0);
    tick();
    check("lat_edge2_valid", out_valid, 0);
    tick();
    check("lat_edge3_valid", out_valid, 1);
    check("lat_edge3_data", out_data, 8'hA5);
    check("lat_edge3_ch", out_ch, 5);
    tick();
    check("hold_valid", out_valid, 0);
    check("hold_data", out_data, 8'hA5);

    // Back-to-back external selects 0..7.
    for (int i = 0; i < int'(N); i++) begin
      sel      = SW'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("seq_last_data", out_data, 8'hA7);

    // Auto-scan for ten accepts: the counter wraps and ends at 2.
    mode     = 1'b1;
    in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    check("scan_after10", scan_idx, 2);
    mode = 1'b0;
    repeat (4) tick();
    check("scan_kept_mode0", scan_idx, 2);
    check("scan_last_ch", out_ch, 1);

    // Stall for two cycles after the second accept; in_valid stays high.
    sel      = 3'd1;
    in_valid = 1'b1;
    tick();
    sel = 3'd2;
    tick();
    stall = 1'b1;
    sel   = 3'd3;
    repeat (2) tick();
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("stall_last_data", out_data, 8'hA3);

    // Scan counter frozen while stalled.
    mode     = 1'b1;
    in_valid = 1'b1;
    tick();
    stall = 1'b1;
    repeat (2) tick();
    check("scan_stalled", scan_idx, 3);
    stall    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    repeat (4) tick();

    // Reset while three items are in flight.
    sel      = 3'd4;
    in_valid = 1'b1;
    repeat (3) tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_scan", scan_idx, 0);
    rst      = 1'b0;
    sel      = 3'd6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_e1", out_valid, 0);
    tick();
    check("post_rst_e2", out_valid, 0);
    tick();
    check("post_rst_e3_valid", out_valid, 1);
    check("post_rst_e3_data", out_data, 8'hA6);

    // Randomized traffic, including stalls, mode changes and occasional resets.
    repeat (3000) begin
      in_data  = {$urandom, $urandom};
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = SW'($urandom_range(0, N - 1));
      mode     = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst      = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer tree, with N = 2**SEL_W channels, each DATA_W bits wide.
- Built as SEL_W layers of 2:1 selection. A register follows every layer, so throughput is one word per clock.
- Carries a valid flag and the selected channel tag alongside the data, and supports a global stall.
- Adds an auto-scan mode: an internal counter steps through all channels round-robin. It serves as the wide/registered successor to the team's small combinational mux trees in datapath and sampling blocks.

Parameters:
- DATA_W, 8, width of each input channel and of out_data.
- SEL_W, 3, select width; channel count N = 2**SEL_W; legal range 1..6; pipeline latency = SEL_W cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request to accept one selection this cycle.
- in_data  input  N*DATA_W  packed channels; channel i occupies bits [i*DATA_W +: DATA_W].
- sel  input  SEL_W  channel index, used only when mode=0.
- mode  input  1  0 = external sel; 1 = auto-scan using the internal counter.
- stall  input  1  freezes the entire pipeline and the scan counter.
- out_valid  output  1  out_data/out_ch hold a valid result this cycle.
- out_data  output  DATA_W  selected channel data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- scan_idx  output  SEL_W  current auto-scan counter value.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On a clk edge with rst=1:
  - all stage valid bits, stage data, stage tags, out_valid, out_data, out_ch and scan_idx go to 0;
  - rst has priority over stall and over in_valid;
  - in-flight items are discarded.
- Acceptance: an input is accepted on an edge where rst=0, stall=0 and in_valid=1. in_valid while stall=1 is ignored; it is not queued.
- Effective select: ES = sel when mode=0, ES = scan_idx when mode=1. mode is sampled per cycle, so it can change between accepted items.
- Layer 1 (registered at acceptance):
  - for j in 0..N/2-1: stage1_data[j] = ES[0] ? ch[2j+1] : ch[2j];
  - remaining select bits ES[SEL_W-1:1], the full tag ES and valid=1 are registered alongside.
- Layer k (k = 2..SEL_W): combines pairs of stage(k-1) words using stage(k-1)'s carried select bit ES[k-1]. The result, the remaining bits, the tag and valid move to stage k.
- Output: the stage SEL_W register drives out_data, out_ch and out_valid.
- Latency: an item accepted at edge t appears with out_valid=1 after edge t+SEL_W, provided no stall cycles occur.
- Bubbles:
  - on a non-stalled edge, a stage's valid bit takes the previous stage's valid (at layer 1, the acceptance condition);
  - the data/tag registers of a stage load only when the incoming valid=1, so a bubble leaves them unchanged;
  - out_data and out_ch therefore hold the last valid result while out_valid=0.
- Stall: while stall=1 (and rst=0), every stage register (valid, data, tag, select bits) and scan_idx hold their values. out_valid remains as-is, so a valid output is presented again on each stalled cycle.
- Scan counter:
  - increments by 1 on each accepted edge where mode=1;
  - wraps from N-1 to 0;
  - holds when mode=0, stalled, or no acceptance;
  - keeps its value across mode switches; only rst clears it.
- Throughput: back-to-back acceptances with no stall produce out_valid high on consecutive cycles. No item is duplicated or dropped.
- SEL_W=1: a single registered 2:1 stage with latency 1.

Test Plan (DATA_W=8, SEL_W=3; channel i = 8'hA0+i unless noted):
- rst high for 2 cycles, then low with in_valid=0: out_valid=0, out_data=0, out_ch=0, scan_idx=0 on every cycle.
- mode=0, sel=5, single in_valid pulse accepted at edge 0: out_valid=1 only after edge 3, with out_data=8'hA5, out_ch=5. From edge 4 on, out_valid=0 and out_data stays 8'hA5.
- mode=0, sel=0..7 on 8 consecutive accepted cycles: out_data = A0..A7 with out_ch = 0..7 on 8 consecutive output cycles, out_valid high with no gaps.
- mode=1, in_valid held for 10 cycles: out_ch sequence 0,1,2,3,4,5,6,7,0,1 with matching data; scan_idx=2 afterwards. A switch to mode=0 keeps scan_idx=2.
- Stream of sel=1,2,3 with stall=1 for 2 cycles after the second acceptance (in_valid=1 during stall): output order A1,A2,A3 is delayed 2 cycles. The output stays constant during the stall, with no extra items, and scan_idx is unchanged when mode=1.
- rst pulsed 1 cycle while 3 items are in flight: out_valid=0 from the next cycle and no in-flight item ever appears. scan_idx=0, and a new item accepted right after reset emerges with standard 3-cycle latency.
